rv32i_dmem: RTL and testbench

- Data-memory responder for the RV32I core's load/store port.
- Accepts word-aligned load/store requests from the execute stage: address, byte enables and pre-shifted write data.
- Returns 32-bit read data and inserts a configurable number of wait states via stall.
- Holds the memory array on-chip; sits between the ALU memory-access port and the rest of the memory map.

---
 rtl/rv32i_dmem_if.sv | 28 ++
 rtl/rv32i_dmem.sv | 98 +++++++++
 tb/tb_rv32i_dmem.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_dmem_if
//  Purpose  : Load/store port bundle between the RV32I execute stage and
//             the on-chip data memory.
//  Revision : 1.0  initial release
// ============================================================================
interface rv32i_dmem_if;
    logic [31:0] addr;
    logic [3:0]  st_be;
    logic        load;
    logic        store;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic        stall;
    logic        access_err;

    modport master (
        output addr, st_be, load, store, wdata,
        input  ld_data, stall, access_err
    );

    modport slave (
        input  addr, st_be, load, store, wdata,
        output ld_data, stall, access_err
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_dmem
//  Purpose  : On-chip RV32I data memory with byte-lane stores and a
//             programmable number of wait states per access.
//             Optional macro RV32I_DMEM_RANGE_CHECK_EN enables out-of-range
//             detection with a one-cycle access_err pulse.
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_dmem #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    rv32i_dmem_if.slave bus
);

    localparam int         c_idx_w = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic         err_q, err_d;

    logic [31:0]  mem [DEPTH_WORDS];

    logic               w_req;
    logic [3:0]         w_cnt;
    logic               w_done;
    logic [31:0]        w_offset;
    logic [c_idx_w-1:0] w_index;
    logic               w_in_range;

    always_comb begin
        w_req    = bus.load | bus.store;
        // In IDLE the counter is zero by construction; the state gates it so a
        // stray count can never leak into a fresh access.
        w_cnt    = (state_q == S_WAIT) ? k_q : 4'd0;
        w_done   = w_req && (w_cnt == c_wait);
        w_offset = bus.addr - BASE_ADDR;
        w_index  = w_offset[c_idx_w+1:2];
`ifdef RV32I_DMEM_RANGE_CHECK_EN
        w_in_range = (w_offset[31:c_idx_w+2] == '0);
`else
        w_in_range = 1'b1;
`endif
    end

    always_comb begin
        state_d = S_IDLE;
        k_d     = 4'd0;
        err_d   = 1'b0;
        if (w_req && !w_done) begin
            state_d = S_WAIT;
            k_d     = w_cnt + 4'd1;
        end
`ifdef RV32I_DMEM_RANGE_CHECK_EN
        err_d = w_done && !w_in_range;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; reset only blocks a store completing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && bus.store && w_done && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.st_be[i]) begin
                    mem[w_index][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Read is combinational so a simultaneous load+store sees the pre-write word.
    assign bus.ld_data    = (bus.load && w_done && w_in_range) ? mem[w_index] : 32'd0;
    assign bus.stall      = w_req && (w_cnt < c_wait);
    assign bus.access_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_dmem
//  Purpose  : Self-checking bench for rv32i_dmem (0 and 3 wait-state builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_dmem;

`ifdef RV32I_DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32i_dmem_if b0 ();
    rv32i_dmem_if b3 ();

    rv32i_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    rv32i_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .bus(b3)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t vecs [17];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic access3(input string nm, input logic ld, input logic st,
                           input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        int   ns;
        logic bad;
        logic done;
        exp_t e;
        sb.push_back('{data: ed, err: ee});
        b3.load = ld; b3.store = st; b3.addr = a; b3.st_be = be; b3.wdata = wd;
        ns = 0; bad = 1'b0; done = 1'b0;
        e  = '{data: 32'd0, err: 1'b0};
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (b3.stall) begin
                ns++;
                if (b3.ld_data !== 32'd0) bad = 1'b1;
            end else begin
                done = 1'b1;
                e = sb.pop_front();
                chk({nm, "_data"}, b3.ld_data, e.data);
            end
            @(posedge clk); #1;
        end
        b3.load = 1'b0; b3.store = 1'b0;
        if (!done) begin
            void'(sb.pop_front());
            chk({nm, "_timeout"}, 32'd1, 32'd0);
        end
        chk({nm, "_stalls"}, 32'(ns), 32'd3);
        chk({nm, "_ld0_in_stall"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({nm, "_err"}, 32'(b3.access_err), 32'(e.err));
        chk({nm, "_no_resid_stall"}, 32'(b3.stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  pat;
        logic [31:0] ld_last;

        vecs[0]  = '{"w0_init",    1'b0, 1'b1, 32'h0000, 4'b1111, 32'h01020304, 32'h0, 1'b0};
        vecs[1]  = '{"w20_init",   1'b0, 1'b1, 32'h0020, 4'b1111, 32'h11223344, 32'h0, 1'b0};
        vecs[2]  = '{"w20_lane2",  1'b0, 1'b1, 32'h0020, 4'b0100, 32'h00AA0000, 32'h0, 1'b0};
        vecs[3]  = '{"r20",        1'b1, 1'b0, 32'h0020, 4'b0000, 32'h0, 32'h11AA3344, 1'b0};
        vecs[4]  = '{"w30_init",   1'b0, 1'b1, 32'h0030, 4'b1111, 32'h00000005, 32'h0, 1'b0};
        vecs[5]  = '{"rw30",       1'b1, 1'b1, 32'h0030, 4'b1111, 32'h00000009, 32'h5, 1'b0};
        vecs[6]  = '{"r30",        1'b1, 1'b0, 32'h0030, 4'b0000, 32'h0, 32'h9, 1'b0};
        vecs[7]  = '{"w40_init",   1'b0, 1'b1, 32'h0040, 4'b1111, 32'h12345678, 32'h0, 1'b0};
        vecs[8]  = '{"w40_be0",    1'b0, 1'b1, 32'h0040, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[9]  = '{"r40",        1'b1, 1'b0, 32'h0040, 4'b0000, 32'h0, 32'h12345678, 1'b0};
        vecs[10] = '{"w44_clr",    1'b0, 1'b1, 32'h0044, 4'b1111, 32'h00000000, 32'h0, 1'b0};
        vecs[11] = '{"w44_lanes",  1'b0, 1'b1, 32'h0044, 4'b1001, 32'hAA5555BB, 32'h0, 1'b0};
        vecs[12] = '{"r46_unalgn", 1'b1, 1'b0, 32'h0046, 4'b0000, 32'h0, 32'hAA0000BB, 1'b0};
        vecs[13] = '{"w1000_oor",  1'b0, 1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0, RC};
        vecs[14] = '{"r0_after",   1'b1, 1'b0, 32'h0000, 4'b0000, 32'h0,
                     RC ? 32'h01020304 : 32'hCAFEF00D, 1'b0};
        vecs[15] = '{"r1000_oor",  1'b1, 1'b0, 32'h1000, 4'b0000, 32'h0,
                     RC ? 32'h0 : 32'hCAFEF00D, RC};
        vecs[16] = '{"w50_init",   1'b0, 1'b1, 32'h0050, 4'b1111, 32'h11111111, 32'h0, 1'b0};

        reset = 1'b1;
        b0.load = 1'b0; b0.store = 1'b0; b0.addr = '0; b0.st_be = '0; b0.wdata = '0;
        b3.load = 1'b0; b3.store = 1'b0; b3.addr = '0; b3.st_be = '0; b3.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ws0_stall", 32'(b0.stall), 32'd0);
        chk("rst_ws0_ld",    b0.ld_data, 32'd0);
        chk("rst_ws0_err",   32'(b0.access_err), 32'd0);
        chk("rst_ws3_stall", 32'(b3.stall), 32'd0);
        chk("rst_ws3_ld",    b3.ld_data, 32'd0);
        chk("rst_ws3_err",   32'(b3.access_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait-state instance: single-cycle store then load.
        b0.store = 1'b1; b0.addr = 32'h10; b0.st_be = 4'b1111; b0.wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ws0_st_stall", 32'(b0.stall), 32'd0);
        chk("ws0_st_ld",    b0.ld_data, 32'd0);
        @(posedge clk); #1;
        b0.store = 1'b0; b0.load = 1'b1;
        @(negedge clk);
        chk("ws0_ld_stall", 32'(b0.stall), 32'd0);
        chk("ws0_ld_data",  b0.ld_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        b0.load = 1'b0;

        for (int i = 0; i < 17; i++) begin
            access3(vecs[i].name, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].be,
                    vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Abort: store dropped after one stall cycle must not write.
        b3.store = 1'b1; b3.addr = 32'h50; b3.st_be = 4'b1111; b3.wdata = 32'h22222222;
        @(negedge clk);
        chk("abort_stall", 32'(b3.stall), 32'd1);
        @(posedge clk); #1;
        b3.store = 1'b0;
        @(negedge clk);
        chk("abort_no_stall", 32'(b3.stall), 32'd0);
        @(posedge clk); #1;
        chk("abort_err", 32'(b3.access_err), 32'd0);
        access3("abort_r50", 1'b1, 1'b0, 32'h50, 4'b0000, 32'h0, 32'h11111111, 1'b0);

        // Reset sampled on the completion edge of a store discards it.
        b3.store = 1'b1; b3.addr = 32'h50; b3.st_be = 4'b1111; b3.wdata = 32'h33333333;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_cmpl_stall", 32'(b3.stall), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; b3.store = 1'b0;
        @(negedge clk);
        chk("rst_after_stall", 32'(b3.stall), 32'd0);
        @(posedge clk); #1;
        access3("rst_r50", 1'b1, 1'b0, 32'h50, 4'b0000, 32'h0, 32'h11111111, 1'b0);

        // Back-to-back: a held load restarts the wait sequence after completing.
        b3.load = 1'b1; b3.addr = 32'h20;
        pat = '0; ld_last = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pat = {pat[6:0], b3.stall};
            if (c == 7) ld_last = b3.ld_data;
            @(posedge clk); #1;
        end
        b3.load = 1'b0;
        chk("b2b_stall_pattern", 32'(pat), 32'h000000EE);
        chk("b2b_second_data",   ld_last, 32'h11AA3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
